ref_gate_generator: RTL and testbench

Generates the measurement gate that the oscillator counter samples. Runs in the REF_CLK domain and, on a 4-phase request from the OPB register side, emits a burst of GATE_NUM high pulses. Each pulse is GATE_LEN REF_CLK cycles long, and pulses are separated by GAP_LEN low cycles. It is the source end of the gate/count interface: the counter enables on GATE, and this block defines the window.

---
 rtl/ref_gate_pkg.sv | 20 ++
 rtl/ref_gate_sync2.sv | 29 ++
 rtl/ref_gate_generator.sv | 224 ++++++++++++++++++++++
 tb/tb_ref_gate_generator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ref_gate_pkg.sv
// ref_gate_pkg
//   Shared definitions for the reference gate generator: FSM state encoding,
//   default widths and the minimum low time between consecutive gates.
//   No ports.
package ref_gate_pkg;

    localparam int LEN_W_DEF = 16;
    localparam int NUM_W_DEF = 8;

    // Shortest low time between two gates, so adjacent pulses never merge.
    localparam int MIN_GAP = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATE_HI = 2'd1,
        GATE_LO = 2'd2,
        DONE    = 2'd3
    } gate_state_t;

endpackage

// File: rtl/ref_gate_sync2.sv
// ref_gate_sync2
//   Two-flop level synchronizer into the clk domain, asynchronously reset.
//   Ports:
//     clk  in   destination clock
//     rst  in   asynchronous active-high reset, clears both flops
//     d    in   asynchronous level
//     q    out  synchronized level, two clk edges behind d
module ref_gate_sync2
    import ref_gate_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ref_gate_generator.sv
// ref_gate_generator
//   Source of the oscillator counter's measurement window. On a 4-phase
//   request it emits GATE_NUM registered high pulses of GATE_LEN REF_CLK
//   cycles, separated by max(GAP_LEN,1) low cycles, then acknowledges.
//
//   Build option: REF_GATE_SYNC_EN -- when defined, START_REQ and ABORT pass
//   through 2-flop synchronizers (2 extra cycles of latency); when undefined
//   they must already be synchronous to REF_CLK.
//
//   Ports:
//     REF_CLK    in   block clock, rising edge
//     OPB_RST    in   asynchronous active-high reset
//     START_REQ  in   4-phase request level
//     ABORT      in   level, ends a running burst early
//     GATE_LEN   in   gate high length (cycles), latched at request
//     GAP_LEN    in   low length between gates (cycles), latched at request
//     GATE_NUM   in   gates per burst, latched at request
//     GATE       out  registered gate to the counter enable
//     BUSY       out  burst in progress
//     ACK        out  4-phase acknowledge
//     ABORTED    out  last burst was ended by ABORT
//     GATE_IDX   out  gates completed in the current or last burst
module ref_gate_generator
    import ref_gate_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             REF_CLK,
    input  logic             OPB_RST,
    input  logic             START_REQ,
    input  logic             ABORT,
    input  logic [LEN_W-1:0] GATE_LEN,
    input  logic [LEN_W-1:0] GAP_LEN,
    input  logic [NUM_W-1:0] GATE_NUM,
    output logic             GATE,
    output logic             BUSY,
    output logic             ACK,
    output logic             ABORTED,
    output logic [NUM_W-1:0] GATE_IDX
);

    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
    localparam logic [LEN_W-1:0] GAP_MIN_L = LEN_W'(MIN_GAP);

    // Counter preload for the low phase: GAP_LEN forced up to MIN_GAP.
    function automatic logic [LEN_W-1:0] gap_load(input logic [LEN_W-1:0] gap);
        logic [LEN_W-1:0] g;
        g = (gap < GAP_MIN_L) ? GAP_MIN_L : gap;
        return g - ONE_L;
    endfunction

    gate_state_t      state, state_n;
    logic [LEN_W-1:0] len_l, len_l_n;
    logic [LEN_W-1:0] gap_l, gap_l_n;
    logic [NUM_W-1:0] num_l, num_l_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [NUM_W-1:0] idx_n;
    logic             gate_n, busy_n, ack_n, aborted_n;
    logic             armed, armed_n;
    logic             req_s, abort_s, warm_ok;
    logic [NUM_W:0]   idx_inc;
    logic             more_gates;

`ifdef REF_GATE_SYNC_EN
    // The synchronizers read 0 for two edges after reset regardless of
    // START_REQ; warm blocks re-arming until their output is meaningful,
    // otherwise a request held across reset would restart the burst.
    logic [1:0] warm;

    ref_gate_sync2 u_req_sync (
        .clk (REF_CLK),
        .rst (OPB_RST),
        .d   (START_REQ),
        .q   (req_s)
    );

    ref_gate_sync2 u_abort_sync (
        .clk (REF_CLK),
        .rst (OPB_RST),
        .d   (ABORT),
        .q   (abort_s)
    );

    always_ff @(posedge REF_CLK or posedge OPB_RST) begin
        if (OPB_RST) warm <= 2'b00;
        else         warm <= {warm[0], 1'b1};
    end

    assign warm_ok = warm[1];
`else
    assign req_s   = START_REQ;
    assign abort_s = ABORT;
    assign warm_ok = 1'b1;
`endif

    assign idx_inc    = {1'b0, GATE_IDX} + {{NUM_W{1'b0}}, 1'b1};
    assign more_gates = idx_inc < {1'b0, num_l};

    always_ff @(posedge REF_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state    <= IDLE;
            len_l    <= '0;
            gap_l    <= '0;
            num_l    <= '0;
            cnt      <= '0;
            armed    <= 1'b0;
            GATE     <= 1'b0;
            BUSY     <= 1'b0;
            ACK      <= 1'b0;
            ABORTED  <= 1'b0;
            GATE_IDX <= '0;
        end else begin
            state    <= state_n;
            len_l    <= len_l_n;
            gap_l    <= gap_l_n;
            num_l    <= num_l_n;
            cnt      <= cnt_n;
            armed    <= armed_n;
            GATE     <= gate_n;
            BUSY     <= busy_n;
            ACK      <= ack_n;
            ABORTED  <= aborted_n;
            GATE_IDX <= idx_n;
        end
    end

    // All outputs are computed here one cycle ahead and registered, so GATE
    // leaves a flop and the counter sees a clean enable.
    always_comb begin
        state_n   = state;
        len_l_n   = len_l;
        gap_l_n   = gap_l;
        num_l_n   = num_l;
        cnt_n     = cnt;
        gate_n    = GATE;
        busy_n    = BUSY;
        ack_n     = ACK;
        aborted_n = ABORTED;
        idx_n     = GATE_IDX;
        // A request is accepted only after req_s has been seen low since
        // reset, so a request interrupted by reset must drop and rise again.
        armed_n   = armed | (~req_s & warm_ok);

        unique case (state)
            IDLE: begin
                gate_n = 1'b0;
                busy_n = 1'b0;
                if (req_s && !ACK && armed) begin
                    len_l_n   = GATE_LEN;
                    gap_l_n   = GAP_LEN;
                    num_l_n   = GATE_NUM;
                    aborted_n = 1'b0;
                    idx_n     = '0;
                    if (GATE_LEN == '0 || GATE_NUM == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = GATE_HI;
                        gate_n  = 1'b1;
                        busy_n  = 1'b1;
                        cnt_n   = GATE_LEN - ONE_L;
                    end
                end
            end

            GATE_HI: begin
                if (abort_s) begin
                    // Abort beats a coinciding last cycle: no increment.
                    state_n   = DONE;
                    gate_n    = 1'b0;
                    busy_n    = 1'b0;
                    aborted_n = 1'b1;
                end else if (cnt == '0) begin
                    idx_n  = idx_inc[NUM_W-1:0];
                    gate_n = 1'b0;
                    if (more_gates) begin
                        state_n = GATE_LO;
                        cnt_n   = gap_load(gap_l);
                    end else begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                    end
                end else begin
                    cnt_n = cnt - ONE_L;
                end
            end

            GATE_LO: begin
                if (abort_s) begin
                    state_n   = DONE;
                    gate_n    = 1'b0;
                    busy_n    = 1'b0;
                    aborted_n = 1'b1;
                end else if (cnt == '0) begin
                    state_n = GATE_HI;
                    gate_n  = 1'b1;
                    cnt_n   = len_l - ONE_L;
                end else begin
                    cnt_n = cnt - ONE_L;
                end
            end

            DONE: begin
                gate_n = 1'b0;
                busy_n = 1'b0;
                // ACK rises one cycle after entry, then waits for req_s low.
                if (!ACK) begin
                    ack_n = 1'b1;
                end else if (!req_s) begin
                    ack_n   = 1'b0;
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                gate_n  = 1'b0;
                busy_n  = 1'b0;
                ack_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ref_gate_generator.sv
// tb_ref_gate_generator
//   Directed bench for ref_gate_generator. Expected gate/busy/ack waveforms
//   come from closed-form burst timing (gate g starts at 1+g*(len+gap')).
//   Works with or without REF_GATE_SYNC_EN (sync adds 2 cycles of latency).
module tb_ref_gate_generator;

    localparam int LEN_W = 16;
    localparam int NUM_W = 8;
`ifdef REF_GATE_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic             ref_clk = 1'b0;
    logic             opb_rst;
    logic             start_req;
    logic             abort;
    logic [LEN_W-1:0] gate_len;
    logic [LEN_W-1:0] gap_len;
    logic [NUM_W-1:0] gate_num;
    logic             gate;
    logic             busy;
    logic             ack;
    logic             aborted;
    logic [NUM_W-1:0] gate_idx;

    int n_checks = 0;
    int n_pass   = 0;

    ref_gate_generator #(.LEN_W(LEN_W), .NUM_W(NUM_W)) dut (
        .REF_CLK   (ref_clk),
        .OPB_RST   (opb_rst),
        .START_REQ (start_req),
        .ABORT     (abort),
        .GATE_LEN  (gate_len),
        .GAP_LEN   (gap_len),
        .GATE_NUM  (gate_num),
        .GATE      (gate),
        .BUSY      (busy),
        .ACK       (ack),
        .ABORTED   (aborted),
        .GATE_IDX  (gate_idx)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    // One full 4-phase transaction. a_t is the model edge (relative to the
    // accepted request) at which the FSM samples ABORT; 0 means no abort.
    task automatic run_burst(input string name, input int len, input int gap,
                             input int num, input int a_t);
        int  gapm, e, e_eff, st, exp_idx;
        bit  zero, ab, g_exp;
        gapm  = (gap == 0) ? 1 : gap;
        zero  = (len == 0) || (num == 0);
        e     = zero ? 1 : 1 + num * len + (num - 1) * gapm;
        ab    = !zero && (a_t >= 2) && (a_t <= e);
        e_eff = ab ? a_t : e;

        gate_len = LEN_W'(len);
        gap_len  = LEN_W'(gap);
        gate_num = NUM_W'(num);
        repeat (4) tick();
        start_req = 1'b1;

        for (int k = 1; k <= e_eff + SL + 2; k++) begin
            int t;
            tick();
            t = k - SL;
            g_exp = 1'b0;
            if (!zero && t < e_eff) begin
                for (int g = 0; g < num; g++) begin
                    st = 1 + g * (len + gapm);
                    if (t >= st && t < st + len) g_exp = 1'b1;
                end
            end
            chk($sformatf("%s gate@%0d", name, k), 32'(gate), 32'(g_exp));
            chk($sformatf("%s busy@%0d", name, k), 32'(busy), 32'((t >= 1) && (t < e_eff)));
            chk($sformatf("%s ack@%0d", name, k), 32'(ack), 32'(t >= e_eff + 1));
            if (t == 1) begin
                chk($sformatf("%s aborted_clr", name), 32'(aborted), 32'd0);
                chk($sformatf("%s idx_clr", name), 32'(gate_idx), 32'd0);
            end
            // Config changes after the latch must not affect the burst.
            if (k == 3) begin
                gate_len = LEN_W'(len + 3);
                gap_len  = LEN_W'(gap + 5);
                gate_num = NUM_W'(num + 1);
            end
            if (ab && k == a_t - 1) abort = 1'b1;
        end

        exp_idx = 0;
        if (ab) begin
            for (int g = 0; g < num; g++)
                if (1 + g * (len + gapm) + len < a_t) exp_idx++;
        end else if (!zero) begin
            exp_idx = num;
        end
        chk($sformatf("%s idx", name), 32'(gate_idx), 32'(exp_idx));
        chk($sformatf("%s aborted", name), 32'(aborted), 32'(ab));

        start_req = 1'b0;
        abort     = 1'b0;
        for (int j = 0; j <= SL; j++) begin
            chk($sformatf("%s ack_hold%0d", name, j), 32'(ack), 32'd1);
            tick();
        end
        chk($sformatf("%s ack_drop", name), 32'(ack), 32'd0);
        chk($sformatf("%s idle_busy", name), 32'(busy), 32'd0);
        chk($sformatf("%s idle_gate", name), 32'(gate), 32'd0);
    endtask

    task automatic reset_mid_gate();
        gate_len = LEN_W'(6);
        gap_len  = LEN_W'(1);
        gate_num = NUM_W'(2);
        repeat (4) tick();
        start_req = 1'b1;
        repeat (SL + 3) tick();
        chk("rst pre_gate", 32'(gate), 32'd1);
        #2 opb_rst = 1'b1;
        #1;
        chk("rst gate", 32'(gate), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst idx", 32'(gate_idx), 32'd0);
        tick();
        opb_rst = 1'b0;
        // Request still held: must not restart.
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("rst hold gate@%0d", k), 32'(gate), 32'd0);
            chk($sformatf("rst hold busy@%0d", k), 32'(busy), 32'd0);
        end
        start_req = 1'b0;
    endtask

    initial begin
        opb_rst   = 1'b1;
        start_req = 1'b0;
        abort     = 1'b0;
        gate_len  = '0;
        gap_len   = '0;
        gate_num  = '0;
        repeat (2) @(posedge ref_clk);
        #1;
        chk("reset gate", 32'(gate), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ack", 32'(ack), 32'd0);
        chk("reset aborted", 32'(aborted), 32'd0);
        chk("reset idx", 32'(gate_idx), 32'd0);
        opb_rst = 1'b0;

        run_burst("basic", 4, 2, 3, 0);
        run_burst("gap0", 5, 0, 2, 0);
        run_burst("num0", 4, 2, 0, 0);
        run_burst("len0", 0, 2, 3, 0);
        run_burst("abort2nd", 8, 3, 4, 15);
        run_burst("after_abort", 2, 1, 2, 0);
        run_burst("abort_last", 3, 1, 2, 8);
        run_burst("abort_gap", 3, 4, 2, 5);
        reset_mid_gate();
        run_burst("after_rst", 3, 2, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
